mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one N:1 select-driven multiplexer (16x1 gate-level mux by default) among N requesters. Each requester raises a request line; the block grants one requester at a time and drives the mux select to route that requester's input to the single shared output. Ownership is bounded by a maximum hold time so that no requester can starve the others.

---
 rtl/mux_rr_arbiter.sv | 109 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner selection for one shared N:1 mux. Registered one-hot grant,
// binary select and a valid qualifier; each ownership lasts at most MAX_HOLD cycles.
module mux_rr_arbiter #(
    parameter int N        = 16,
    parameter int SW       = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] sel,
    output logic          sel_valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        r_state;
    logic [SW-1:0] r_ptr;
    logic [SW-1:0] r_sel;
    logic [3:0]    r_cnt;
    logic [N-1:0]  r_gnt;
    logic          r_valid;

    logic [SW:0]   w_head;
    logic [SW:0]   w_next;
    logic          w_release;

    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] x);
        if (x == SW'(N - 1)) return '0;
        return x + 1'b1;
    endfunction

    // Returns {found, index}. Scanned from the far end so the nearest hit wins last.
    function automatic logic [SW:0] pick(input logic [SW-1:0] start, input logic [N-1:0] r);
        logic          found;
        logic [SW-1:0] idx;
        logic [SW:0]   pos;
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, start} + (SW+1)'(k);
            if (pos >= (SW+1)'(N)) pos = pos - (SW+1)'(N);
            if (r[pos[SW-1:0]]) begin
                found = 1'b1;
                idx   = pos[SW-1:0];
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [N-1:0] onehot(input logic [SW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign w_head    = pick(r_ptr, req);
    assign w_next    = pick(wrap_inc(r_sel), req);
    assign w_release = !req[r_sel] || (r_cnt == 4'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_head[SW]) begin
                        r_gnt   <= onehot(w_head[SW-1:0]);
                        r_sel   <= w_head[SW-1:0];
                        r_valid <= 1'b1;
                        r_cnt   <= 4'd1;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_ptr <= wrap_inc(r_sel);
                        // Hand over on the same edge; a lone requester re-picks itself.
                        if (w_next[SW]) begin
                            r_gnt <= onehot(w_next[SW-1:0]);
                            r_sel <= w_next[SW-1:0];
                            r_cnt <= 4'd1;
                        end else begin
                            r_gnt   <= '0;
                            r_valid <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign sel_valid = r_valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed scenarios plus randomized traffic, all compared against a cycle model
// built from the arbitration rules with plain integers.
module tb_mux_rr_arbiter;

    localparam int N        = 16;
    localparam int SW       = 4;
    localparam int MAX_HOLD = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [SW-1:0] sel;
    logic          sel_valid;

    int checks = 0;
    int errors = 0;

    // reference model: owner -1 means nothing granted
    int m_owner, m_ptr, m_cnt, m_sel;

    mux_rr_arbiter #(.N(N), .SW(SW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt), .sel(sel), .sel_valid(sel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick_ref(input int start, input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic [N-1:0] q);
        int n;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            n = pick_ref(m_ptr, q);
            if (n >= 0) begin m_owner = n; m_sel = n; m_cnt = 1; end
        end else if (!q[m_owner] || m_cnt == MAX_HOLD) begin
            m_ptr = (m_owner + 1) % N;
            n = pick_ref(m_ptr, q);
            if (n >= 0) begin m_owner = n; m_sel = n; m_cnt = 1; end
            else m_owner = -1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive at negedge, clock once, then compare against the model
    task automatic step(input logic r, input logic [N-1:0] q);
        logic [N-1:0] eg;
        @(negedge clk);
        rst = r;
        req = q;
        @(posedge clk);
        model_edge(r, q);
        #1;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk("model_gnt", 32'(gnt), 32'(eg));
        chk("model_sel", 32'(sel), 32'(m_sel));
        chk("model_valid", 32'(sel_valid), 32'(m_owner >= 0));
        chk("inv_valid_or", 32'(sel_valid), 32'(|gnt));
        chk("inv_gnt_sel", 32'(gnt[sel]), 32'(sel_valid));
    endtask

    initial begin
        logic [N-1:0] rq;
        rst = 1'b1;
        req = '0;

        // reset with everyone requesting
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'hFFFF);
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_sel", 32'(sel), 32'h0);
            chk("rst_valid", 32'(sel_valid), 32'h0);
        end
        step(1'b0, 16'hFFFF);
        chk("first_gnt", 32'(gnt), 32'h0001);
        chk("first_sel", 32'(sel), 32'h0);
        chk("first_valid", 32'(sel_valid), 32'h1);

        // single requester rewraps at MAX_HOLD with no gap
        step(1'b1, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 16'h0020);
            chk("single_gnt", 32'(gnt), 32'h0020);
            chk("single_sel", 32'(sel), 32'd5);
        end
        step(1'b0, 16'h0000);
        chk("single_drop_gnt", 32'(gnt), 32'h0);
        chk("single_drop_valid", 32'(sel_valid), 32'h0);
        chk("single_drop_sel", 32'(sel), 32'd5);
        step(1'b0, 16'h0000);
        chk("idle_sel_hold", 32'(sel), 32'd5);

        // two-way rotation across the wrap point
        step(1'b1, 16'h0000);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 16'h8001);
            chk("rot_gnt", 32'(gnt), ((k / MAX_HOLD) % 2 == 0) ? 32'h0001 : 32'h8000);
            chk("rot_sel", 32'(sel), ((k / MAX_HOLD) % 2 == 0) ? 32'd0 : 32'd15);
        end

        // early release of owner 3 hands to 7
        step(1'b1, 16'h0000);
        step(1'b0, 16'h0088);
        chk("early_gnt3a", 32'(gnt), 32'h0008);
        step(1'b0, 16'h0088);
        chk("early_gnt3b", 32'(gnt), 32'h0008);
        @(negedge clk);
        req = 16'h0080;
        #1;
        chk("early_trailing", 32'(gnt), 32'h0008);
        step(1'b0, 16'h0080);
        chk("early_gnt7", 32'(gnt), 32'h0080);
        chk("early_sel7", 32'(sel), 32'd7);
        step(1'b0, 16'h0080);
        step(1'b0, 16'h0080);
        step(1'b0, 16'h0080);
        chk("early_cnt_restart", 32'(gnt), 32'h0080);

        // pointer fairness after owner 9
        step(1'b1, 16'h0000);
        step(1'b0, 16'h0200);
        chk("fair_own9", 32'(sel), 32'd9);
        step(1'b0, 16'h0000);
        step(1'b0, 16'h0301);
        chk("fair_wrap0", 32'(gnt), 32'h0001);
        step(1'b0, 16'h0300);
        chk("fair_then8", 32'(gnt), 32'h0100);
        step(1'b0, 16'h0200);
        chk("fair_then9", 32'(gnt), 32'h0200);

        // reset mid-grant clears the pointer
        step(1'b1, 16'h0000);
        step(1'b0, 16'h1000);
        step(1'b0, 16'h1000);
        chk("mid_own12", 32'(sel), 32'd12);
        step(1'b1, 16'h1001);
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_sel", 32'(sel), 32'd0);
        step(1'b0, 16'h1001);
        chk("mid_after_gnt", 32'(gnt), 32'h0001);

        // randomized traffic, requests mostly held to build queues
        rq = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) rq = N'($urandom & $urandom);
            else if ($urandom_range(0, 3) == 0) rq = rq & ~(N'(1) << $urandom_range(0, N - 1));
            step($urandom_range(0, 49) == 0, rq);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
